address_split: RTL and testbench

ADDRESS_SPLIT -- requirements
Module: address_split

---
 rtl/address_split.sv | 95 +++++++++
 tb/tb_address_split.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/address_split.sv
// Splits a linear address into (column, row) by BLOCK_SIZE using a
// multi-cycle restoring divider. Results are held until the next operation completes.
module address_split #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 10
) (
  input  logic                    Clk,
  input  logic                    nRst,
  input  logic                    Start,
  input  logic [2*DATA_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]   OutputX,
  output logic [DATA_WIDTH-1:0]   OutputY,
  output logic                    Overflow,
  output logic                    Ready,
  output logic [1:0]              fsm_state
);

  localparam int AW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(AW) + 1;
  localparam logic [DATA_WIDTH:0] DIVISOR = (DATA_WIDTH + 1)'(BLOCK_SIZE);
  localparam logic [CW-1:0] LAST = CW'(AW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       quot_q;
  logic [DATA_WIDTH:0] rem_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_WIDTH:0] rem_shift;
  logic                fits;

  // One restoring-division step: bring in the next dividend bit (MSB first).
  always_comb begin
    rem_shift = (rem_q << 1) | {{DATA_WIDTH{1'b0}}, addr_q[AW-1]};
    fits      = (rem_shift >= DIVISOR);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = DIVIDE;
      DIVIDE:  if (cnt_q == LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Ready     = (state == IDLE);
  assign fsm_state = state;

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      addr_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      OutputX  <= '0;
      OutputY  <= '0;
      Overflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (Start) begin
            addr_q <= Address;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
          end
        end
        DIVIDE: begin
          addr_q <= addr_q << 1;
          rem_q  <= fits ? (rem_shift - DIVISOR) : rem_shift;
          quot_q <= {quot_q[AW-2:0], fits};
          cnt_q  <= cnt_q + 1'b1;
        end
        FINISH: begin
          // Remainder is always below DIVISOR, so it fits in DATA_WIDTH bits.
          OutputX  <= rem_q[DATA_WIDTH-1:0];
          OutputY  <= quot_q[DATA_WIDTH-1:0];
          Overflow <= |quot_q[AW-1:DATA_WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_address_split.sv
// Directed and round-trip bench for address_split (DATA_WIDTH=16, BLOCK_SIZE=10).
module tb_address_split;

  logic        Clk;
  logic        nRst;
  logic        Start;
  logic [31:0] Address;
  logic [15:0] OutputX;
  logic [15:0] OutputY;
  logic        Overflow;
  logic        Ready;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prev_x = '0;
  logic [15:0] prev_y = '0;
  logic        prev_o = 1'b0;

  address_split #(.DATA_WIDTH(16), .BLOCK_SIZE(10)) dut (
    .Clk       (Clk),
    .nRst      (nRst),
    .Start     (Start),
    .Address   (Address),
    .OutputX   (OutputX),
    .OutputY   (OutputY),
    .Overflow  (Overflow),
    .Ready     (Ready),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one operation, verify hold behaviour, latency and results.
  task automatic run_op(input string tag, input logic [31:0] addr,
                        input logic [15:0] ex, input logic [15:0] ey, input logic eo);
    int n;
    @(negedge Clk);
    Start   = 1'b1;
    Address = addr;
    @(posedge Clk); #1;
    check({tag, "_ready_fall"}, Ready, 0);
    Start   = 1'b0;
    Address = $urandom;
    n = 0;
    while (!Ready && n < 100) begin
      @(posedge Clk); #1;
      n++;
      if (n == 1 || n == 32) begin
        check({tag, "_hold_x"}, OutputX, prev_x);
        check({tag, "_hold_y"}, OutputY, prev_y);
        check({tag, "_hold_o"}, Overflow, prev_o);
      end
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_x"}, OutputX, ex);
    check({tag, "_y"}, OutputY, ey);
    check({tag, "_ovf"}, Overflow, eo);
    prev_x = ex;
    prev_y = ey;
    prev_o = eo;
  endtask

  initial begin
    int n;
    int low_cycles;
    logic [15:0] rx;
    logic [15:0] ry;

    nRst    = 1'b0;
    Start   = 1'b0;
    Address = '0;
    #12;
    check("reset_ready", Ready, 1);
    check("reset_x", OutputX, 0);
    check("reset_y", OutputY, 0);
    check("reset_ovf", Overflow, 0);
    check("reset_state", fsm_state, 0);
    @(negedge Clk);
    nRst = 1'b1;

    // Basic split and small boundaries
    run_op("a54", 32'd54, 16'd4, 16'd5, 1'b0);
    run_op("a9", 32'd9, 16'd9, 16'd0, 1'b0);
    run_op("a10", 32'd10, 16'd0, 16'd1, 1'b0);
    run_op("a0", 32'd0, 16'd0, 16'd0, 1'b0);
    run_op("amax", 32'd655359, 16'd9, 16'd65535, 1'b0);
    run_op("aovf", 32'd655360, 16'd0, 16'd0, 1'b1);
    run_op("afull", 32'hFFFF_FFFF, 16'd5, 16'h9999, 1'b1);

    // Start/Address activity during DIVIDE must be ignored
    @(negedge Clk);
    Start   = 1'b1;
    Address = 32'd54;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 1;
    repeat (5) begin @(posedge Clk); #1; n++; end
    Address = 32'd999;
    Start   = 1'b1;
    repeat (2) begin @(posedge Clk); #1; n++; end
    Start = 1'b0;
    while (!Ready && n < 100) begin @(posedge Clk); #1; n++; end
    check("ign_latency", n, 34);
    check("ign_x", OutputX, 4);
    check("ign_y", OutputY, 5);
    low_cycles = 0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (!Ready) low_cycles++;
    end
    check("ign_single_busy", low_cycles, 0);
    prev_x = 16'd4;
    prev_y = 16'd5;
    prev_o = 1'b0;

    // Asynchronous reset mid-DIVIDE aborts and clears results
    @(negedge Clk);
    Start   = 1'b1;
    Address = 32'd777;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #2;
    nRst = 1'b0;
    #1;
    check("arst_ready", Ready, 1);
    check("arst_x", OutputX, 0);
    check("arst_y", OutputY, 0);
    check("arst_ovf", Overflow, 0);
    @(negedge Clk);
    nRst   = 1'b1;
    prev_x = '0;
    prev_y = '0;
    prev_o = 1'b0;
    run_op("a123", 32'd123, 16'd3, 16'd12, 1'b0);

    // Round trip from random (column, row) pairs
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom_range(0, 9));
      ry = 16'($urandom_range(0, 65535));
      run_op("rt", 32'(ry) * 32'd10 + 32'(rx), rx, ry, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
